// File: rtl/akuma_pkg.sv
// Shared types and screen/sprite constants for the Akuma motion controller.
package akuma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_JUMP  = 2'd2,
    ST_PUNCH = 2'd3
  } akuma_state_e;

  localparam logic [1:0] SPR_IDLE  = 2'd0;
  localparam logic [1:0] SPR_WALK  = 2'd1;
  localparam logic [1:0] SPR_JUMP  = 2'd2;
  localparam logic [1:0] SPR_PUNCH = 2'd3;

  localparam int SCREEN_W = 640;
  localparam int SPRITE_W = 139;
  localparam int SPRITE_H = 161;

  localparam logic [9:0] GROUND_Y = 10'd300;
  localparam logic [9:0] X_MAX    = 10'd501;
  localparam logic [9:0] X_RESET  = 10'd80;

  // Horizontal step in 11-bit signed space, clamped to [0, x_max] so it never wraps.
  function automatic logic [9:0] move_x(input logic [9:0] x, input logic left,
                                        input logic right, input logic [3:0] step,
                                        input logic [9:0] x_max);
    logic signed [10:0] nx;
    nx = $signed({1'b0, x});
    if (left && !right) begin
      nx = nx - $signed({7'd0, step});
    end else if (right && !left) begin
      nx = nx + $signed({7'd0, step});
    end
    if (nx < 11'sd0) begin
      return 10'd0;
    end
    if (nx > $signed({1'b0, x_max})) begin
      return x_max;
    end
    return nx[9:0];
  endfunction

endpackage

// File: rtl/akuma_motion_ctrl_if.sv
// Button inputs and sprite-position outputs of the motion controller.
// No valid/ready here: the controller samples keys once per frame tick and its
// outputs are registered, holding valid from the cycle after a tick until the next tick.
interface akuma_motion_ctrl_if import akuma_pkg::*; ;
  logic         key_left;
  logic         key_right;
  logic         key_jump;
  logic         key_punch;
  logic [9:0]   AkumaX;
  logic [9:0]   AkumaY;
  logic [1:0]   sprite_sel;
  logic [1:0]   anim_frame;
  logic         busy;
  akuma_state_e state_dbg;

  modport master (
    output key_left, key_right, key_jump, key_punch,
    input  AkumaX, AkumaY, sprite_sel, anim_frame, busy, state_dbg
  );

  modport slave (
    input  key_left, key_right, key_jump, key_punch,
    output AkumaX, AkumaY, sprite_sel, anim_frame, busy, state_dbg
  );
endinterface

// File: rtl/vsync_tick_gen.sv
// Two-flop synchroniser for raw vsync plus rising-edge detect giving a one-cycle frame tick.
module vsync_tick_gen (
   input  logic clk,
   input  logic rst_n,
   input  logic vs,
   output logic tick
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = vs;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/akuma_motion_ctrl.sv
// Akuma sprite motion FSM (IDLE/WALK/JUMP/PUNCH), advanced once per vsync tick.
// Optional macro AKUMA_AIR_CONTROL_EN lets left/right steer X while airborne.
module akuma_motion_ctrl
   import akuma_pkg::akuma_state_e, akuma_pkg::ST_IDLE, akuma_pkg::ST_WALK,
          akuma_pkg::ST_JUMP, akuma_pkg::ST_PUNCH, akuma_pkg::X_RESET, akuma_pkg::move_x;
#(
   parameter logic [9:0] GROUND_Y    = akuma_pkg::GROUND_Y,
   parameter logic [9:0] X_MAX       = akuma_pkg::X_MAX,
   parameter int         WALK_STEP   = 4,
   parameter int         JUMP_V0     = -16,
   parameter int         PUNCH_TICKS = 12,
   parameter int         ANIM_DIV    = 6
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   input  logic                vs,
   akuma_motion_ctrl_if.slave  bus
);

   localparam logic [3:0]        STEP       = 4'(WALK_STEP);
   localparam logic signed [5:0] V0         = 6'(JUMP_V0);
   localparam logic [3:0]        PCNT_LAST  = 4'(PUNCH_TICKS - 1);
   localparam logic [3:0]        DIV_LAST   = 4'(ANIM_DIV - 1);

   logic tick;

   vsync_tick_gen u_tick (
      .clk   (vga_clk),
      .rst_n (reset_n),
      .vs    (vs),
      .tick  (tick)
   );

   akuma_state_e      state_q, state_d;
   logic [9:0]        x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic signed [5:0] v_q, v_d;
   logic [3:0]        pcnt_q, pcnt_d;
   logic [3:0]        div_q, div_d;
   logic [1:0]        frame_q, frame_d;
   logic              busy_q, busy_d;
   logic              punch_prev_q, punch_prev_d;

   logic              walk_one;
   logic              punch_rise;
   logic              walking;
   logic [3:0]        div_base;
   logic [1:0]        frame_base;
   logic signed [10:0] y_sum;
   logic signed [5:0] v_inc;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      v_d          = v_q;
      pcnt_d       = pcnt_q;
      div_d        = div_q;
      frame_d      = frame_q;
      punch_prev_d = punch_prev_q;

      walk_one   = bus.key_left ^ bus.key_right;
      punch_rise = bus.key_punch & ~punch_prev_q;
      walking    = (state_q == ST_WALK);
      div_base   = walking ? div_q : 4'd0;
      frame_base = walking ? frame_q : 2'd0;
      y_sum      = $signed({1'b0, y_q}) + $signed({{5{v_q[5]}}, v_q});
      v_inc      = v_q + 6'sd1;

      if (tick) begin
         punch_prev_d = bus.key_punch;
         unique case (state_q)
            ST_IDLE, ST_WALK: begin
               if (bus.key_jump) begin
                  state_d = ST_JUMP;
                  v_d     = V0;
                  frame_d = 2'd0;
               end else if (punch_rise) begin
                  state_d = ST_PUNCH;
                  pcnt_d  = 4'd0;
                  frame_d = 2'd0;
               end else if (walk_one) begin
                  state_d = ST_WALK;
                  x_d     = move_x(x_q, bus.key_left, bus.key_right, STEP, X_MAX);
                  // The entry tick counts as the first tick of a fresh frame period.
                  if (div_base == DIV_LAST) begin
                     div_d   = 4'd0;
                     frame_d = frame_base + 2'd1;
                  end else begin
                     div_d   = div_base + 4'd1;
                     frame_d = frame_base;
                  end
               end else begin
                  state_d = ST_IDLE;
                  frame_d = 2'd0;
               end
            end
            ST_JUMP: begin
`ifdef AKUMA_AIR_CONTROL_EN
               x_d = move_x(x_q, bus.key_left, bus.key_right, STEP, X_MAX);
`else
               x_d = x_q;
`endif
               if (y_sum >= $signed({1'b0, GROUND_Y})) begin
                  state_d = ST_IDLE;
                  y_d     = GROUND_Y;
                  v_d     = 6'sd0;
                  frame_d = 2'd0;
               end else begin
                  y_d     = y_sum[9:0];
                  v_d     = v_inc;
                  frame_d = v_inc[5] ? 2'd0 : 2'd1;
               end
            end
            ST_PUNCH: begin
               if (pcnt_q == PCNT_LAST) begin
                  state_d = ST_IDLE;
                  pcnt_d  = 4'd0;
                  frame_d = 2'd0;
               end else begin
                  pcnt_d  = pcnt_q + 4'd1;
                  frame_d = pcnt_d[3:2];
               end
            end
         endcase
      end

      busy_d = (state_d == ST_JUMP) || (state_d == ST_PUNCH);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         x_q          <= X_RESET;
         y_q          <= GROUND_Y;
         v_q          <= 6'sd0;
         pcnt_q       <= 4'd0;
         div_q        <= 4'd0;
         frame_q      <= 2'd0;
         busy_q       <= 1'b0;
         punch_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         v_q          <= v_d;
         pcnt_q       <= pcnt_d;
         div_q        <= div_d;
         frame_q      <= frame_d;
         busy_q       <= busy_d;
         punch_prev_q <= punch_prev_d;
      end
   end

   assign bus.AkumaX     = x_q;
   assign bus.AkumaY     = y_q;
   assign bus.sprite_sel = state_q;
   assign bus.anim_frame = frame_q;
   assign bus.busy       = busy_q;
   assign bus.state_dbg  = state_q;

endmodule
